// File: rtl/ddr4_pkg.sv
// Shared types and default widths for the DDR4 memory-bus requester slice.
package ddr4_pkg;

  localparam int unsigned PADDR_BITS_DEF = 19;
  localparam int unsigned DATA_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_RESP
  } req_state_e;

  typedef struct packed {
    logic [PADDR_BITS_DEF-1:0] addr;
    logic                      we;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/ddr4_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate count.
module ddr4_req_fifo
  import ddr4_pkg::*;
#(
  parameter type         T     = mem_req_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic push_in,
  input  T     push_data_in,
  input  logic pop_in,
  output T     head_out,
  output logic full_out,
  output logic empty_out
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;
  T            mem_q [DEPTH];

  always_comb begin
    full_out  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    empty_out = (wr_ptr_q == rd_ptr_q);
    do_push   = push_in && !full_out;
    do_pop    = pop_in && !empty_out;
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, do_pop};
    head_out  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_in;
  end

endmodule

// File: rtl/ddr4_mem_requester.sv
// Client-side initiator for the DDR4 controller: queues requests, issues them
// one at a time, drives write data on the shared bus and times out reads.
module ddr4_mem_requester
  import ddr4_pkg::*;
#(
  parameter int unsigned PADDR_BITS = PADDR_BITS_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [PADDR_BITS-1:0] req_addr_in,
  input  logic                  req_we_in,
  input  logic [DATA_WIDTH-1:0] req_wdata_in,
  output logic                  resp_valid_out,
  output logic                  resp_is_write_out,
  output logic                  resp_error_out,
  output logic [DATA_WIDTH-1:0] resp_data_out,
  output logic                  mem_bus_valid_out,
  input  logic                  mem_bus_ready_in,
  output logic [PADDR_BITS-1:0] mem_bus_addr_out,
  output logic                  mem_bus_we_out,
  input  logic                  mem_bus_valid_in,
  output logic                  mem_bus_ready_out,
  inout  wire  [DATA_WIDTH-1:0] mem_bus_value_io
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef struct packed {
    logic [PADDR_BITS-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_state_e            state_q, state_d;
  req_t                  cur_q, cur_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  resp_we_q, resp_we_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  req_t push_req, fifo_head;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic drive_bus;

  always_comb begin
    push_req.addr  = req_addr_in;
    push_req.we    = req_we_in;
    push_req.wdata = req_wdata_in;
    // Ready is held low during reset so nothing is accepted into a flushing FIFO.
    req_ready_out  = !fifo_full && !rst_in;
    fifo_push      = req_valid_in && req_ready_out;
  end

  ddr4_req_fifo #(
    .T     (req_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .push_in      (fifo_push),
    .push_data_in (push_req),
    .pop_in       (fifo_pop),
    .head_out     (fifo_head),
    .full_out     (fifo_full),
    .empty_out    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    resp_we_d   = resp_we_q;
    resp_err_d  = resp_err_q;
    resp_data_d = resp_data_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_head;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_bus_ready_in) begin
          cnt_d       = '0;
          resp_we_d   = cur_q.we;
          resp_err_d  = 1'b0;
          resp_data_d = '0;
          state_d     = cur_q.we ? ST_RESP : ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Data beats the timeout when both land in the final waiting cycle.
        if (mem_bus_valid_in) begin
          resp_data_d = mem_bus_value_io;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
          resp_err_d = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      cnt_q       <= '0;
      resp_we_q   <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      resp_we_q   <= resp_we_d;
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_comb begin
    mem_bus_valid_out = (state_q == ST_ISSUE);
    mem_bus_addr_out  = mem_bus_valid_out ? cur_q.addr : '0;
    mem_bus_we_out    = mem_bus_valid_out && cur_q.we;
    mem_bus_ready_out = (state_q == ST_WAIT_RD);
    resp_valid_out    = (state_q == ST_RESP);
    resp_is_write_out = resp_valid_out && resp_we_q;
    resp_error_out    = resp_valid_out && resp_err_q;
    resp_data_out     = resp_valid_out ? resp_data_q : '0;
    drive_bus         = mem_bus_valid_out && cur_q.we;
  end

  assign mem_bus_value_io = drive_bus ? cur_q.wdata : 'z;

endmodule

// File: tb/tb_ddr4_mem_requester.sv
// Bench for ddr4_mem_requester: transaction-level reference model compared
// every cycle, directed scenarios with literal timing, then random traffic.
module tb_ddr4_mem_requester;

  localparam int PA      = 19;
  localparam int DW      = 64;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          req_valid_in = 1'b0;
  logic          req_ready_out;
  logic [PA-1:0] req_addr_in = '0;
  logic          req_we_in = 1'b0;
  logic [DW-1:0] req_wdata_in = '0;
  logic          resp_valid_out, resp_is_write_out, resp_error_out;
  logic [DW-1:0] resp_data_out;
  logic          mem_bus_valid_out;
  logic          mem_bus_ready_in = 1'b0;
  logic [PA-1:0] mem_bus_addr_out;
  logic          mem_bus_we_out;
  logic          mem_bus_valid_in = 1'b0;
  logic          mem_bus_ready_out;
  logic [DW-1:0] ctl_data = '0;
  wire  [DW-1:0] mem_bus_value_io;

  assign mem_bus_value_io = mem_bus_valid_in ? ctl_data : 'z;

  ddr4_mem_requester #(
    .PADDR_BITS (PA),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .req_valid_in      (req_valid_in),
    .req_ready_out     (req_ready_out),
    .req_addr_in       (req_addr_in),
    .req_we_in         (req_we_in),
    .req_wdata_in      (req_wdata_in),
    .resp_valid_out    (resp_valid_out),
    .resp_is_write_out (resp_is_write_out),
    .resp_error_out    (resp_error_out),
    .resp_data_out     (resp_data_out),
    .mem_bus_valid_out (mem_bus_valid_out),
    .mem_bus_ready_in  (mem_bus_ready_in),
    .mem_bus_addr_out  (mem_bus_addr_out),
    .mem_bus_we_out    (mem_bus_we_out),
    .mem_bus_valid_in  (mem_bus_valid_in),
    .mem_bus_ready_out (mem_bus_ready_out),
    .mem_bus_value_io  (mem_bus_value_io)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Controller stand-in: either random or delay-programmed reactions.
  bit            ctl_random = 1'b0;
  int            rdy_delay  = -1;
  int            dat_delay  = -1;
  int            stray_cyc  = -1;
  logic [DW-1:0] dat_value  = '0;
  int            vcnt = 0, rcnt = 0;

  always @(posedge clk_in) begin
    cyc++;
    #1;
    vcnt = mem_bus_valid_out ? vcnt + 1 : 0;
    rcnt = mem_bus_ready_out ? rcnt + 1 : 0;
    if (ctl_random) begin
      mem_bus_ready_in = ($urandom_range(0, 2) == 0);
      mem_bus_valid_in = !(mem_bus_valid_out && mem_bus_we_out) && ($urandom_range(0, 29) == 0);
      ctl_data         = {$urandom, $urandom};
    end else begin
      mem_bus_ready_in = (rdy_delay >= 0) && (vcnt >= rdy_delay + 1);
      mem_bus_valid_in = ((dat_delay > 0) && (rcnt == dat_delay)) || (cyc == stray_cyc);
      ctl_data         = (cyc == stray_cyc) ? 64'h5757_5757_5757_5757 : dat_value;
    end
  end

  // Reference model: a request queue plus timestamps for the request in flight.
  typedef struct {
    logic [PA-1:0] addr;
    bit            we;
    logic [DW-1:0] wdata;
  } mreq_t;

  typedef struct {
    int            cyc;
    logic [PA-1:0] addr;
    bit            we;
    bit            err;
    logic [DW-1:0] data;
  } rsp_t;

  mreq_t         mq[$];
  rsp_t          rlog[$];
  mreq_t         cur;
  bit            has_cur = 1'b0;
  int            issue_at = -1, acc_at = -1, resp_at = -1;
  bit            rerr = 1'b0;
  logic [DW-1:0] rdata = '0;
  bit            chk_en = 1'b0;
  bit            e_ready, e_issue, e_wait, e_resp;
  int            n;

  always @(negedge clk_in) begin
    if (chk_en) begin
      n       = cyc;
      e_ready = (mq.size() < DEPTH) && !rst_in;
      e_issue = has_cur && (n >= issue_at) && (acc_at < 0);
      e_wait  = has_cur && !cur.we && (acc_at >= 0) && (resp_at < 0);
      e_resp  = has_cur && (resp_at == n);

      check("req_ready",  64'(req_ready_out),     64'(e_ready));
      check("bus_valid",  64'(mem_bus_valid_out), 64'(e_issue));
      check("bus_addr",   64'(mem_bus_addr_out),  e_issue ? 64'(cur.addr) : 64'd0);
      check("bus_we",     64'(mem_bus_we_out),    64'(e_issue && cur.we));
      check("bus_rdy",    64'(mem_bus_ready_out), 64'(e_wait));
      check("resp_valid", 64'(resp_valid_out),    64'(e_resp));
      check("resp_we",    64'(resp_is_write_out), 64'(e_resp && cur.we));
      check("resp_err",   64'(resp_error_out),    64'(e_resp && rerr));
      check("resp_data",  resp_data_out,          e_resp ? rdata : 64'd0);
      if (e_issue && cur.we) check("bus_wdata", mem_bus_value_io, cur.wdata);
      if (e_resp) rlog.push_back('{n, cur.addr, cur.we, rerr, rdata});

      if (rst_in) begin
        mq.delete();
        has_cur = 1'b0;
      end else begin
        if (has_cur) begin
          if (e_resp) begin
            has_cur = 1'b0;
          end else if (e_issue && mem_bus_ready_in) begin
            acc_at = n;
            if (cur.we) begin
              resp_at = n + 1; rerr = 1'b0; rdata = '0;
            end
          end else if (e_wait) begin
            if (mem_bus_valid_in) begin
              resp_at = n + 1; rerr = 1'b0; rdata = ctl_data;
            end else if (n == acc_at + TIMEOUT - 1) begin
              resp_at = n + 1; rerr = 1'b1; rdata = '0;
            end
          end
        end else if (mq.size() != 0) begin
          cur      = mq.pop_front();
          has_cur  = 1'b1;
          issue_at = n + 1;
          acc_at   = -1;
          resp_at  = -1;
        end
        if (req_valid_in && e_ready) mq.push_back('{req_addr_in, req_we_in, req_wdata_in});
      end
    end
  end

  task automatic push(input logic [PA-1:0] a, input bit we, input logic [DW-1:0] d, output int t);
    int g = 0;
    req_valid_in = 1'b1; req_addr_in = a; req_we_in = we; req_wdata_in = d;
    while (!req_ready_out && g < 1000) begin tick(); g++; end
    check("push_accept", 64'(req_ready_out), 64'd1);
    t = cyc;
    tick();
    req_valid_in = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    int g = 0;
    while (rlog.size() < target && g < 1500) begin tick(); g++; end
    check("resp_arrived", 64'(rlog.size() >= target), 64'd1);
    repeat (2) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, base, g;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    check("ready_after_reset", 64'(req_ready_out), 64'd1);
    check("idle_after_reset", 64'(mem_bus_valid_out), 64'd0);
    tick();

    // Single write: controller accepts 5 cycles after valid rises.
    rdy_delay = 5; dat_delay = -1;
    base = rlog.size();
    push(19'h00ABC, 1'b1, 64'hDEAD_BEEF_0000_0001, t);
    wait_resp(base + 1);
    check("wr_resp_cycle", 64'(rlog[base].cyc), 64'(t + 8));
    check("wr_resp_we",    64'(rlog[base].we),  64'd1);
    check("wr_resp_data",  rlog[base].data,     64'd0);

    // Single read returned 30 cycles after acceptance.
    dat_value = 64'hCAFE_F00D_1234_5678; dat_delay = 30;
    base = rlog.size();
    push(19'h01234, 1'b0, '0, t);
    wait_resp(base + 1);
    check("rd_resp_cycle", 64'(rlog[base].cyc), 64'(t + 38));
    check("rd_resp_data",  rlog[base].data,     64'hCAFE_F00D_1234_5678);
    check("rd_resp_err",   64'(rlog[base].err), 64'd0);

    // Timeout, then a stray return while idle.
    rdy_delay = 0; dat_delay = -1;
    base = rlog.size();
    push(19'h00777, 1'b0, '0, t);
    wait_resp(base + 1);
    check("to_resp_cycle", 64'(rlog[base].cyc), 64'(t + 2 + TIMEOUT));
    check("to_resp_err",   64'(rlog[base].err), 64'd1);
    check("to_resp_data",  rlog[base].data,     64'd0);
    stray_cyc = cyc + 2;
    repeat (10) tick();
    check("stray_ignored", 64'(rlog.size()), 64'(base + 1));

    // Data arrives in the final waiting cycle.
    dat_value = 64'h0123_4567_89AB_CDEF; dat_delay = TIMEOUT - 1;
    base = rlog.size();
    push(19'h00555, 1'b0, '0, t);
    wait_resp(base + 1);
    check("tie_resp_cycle", 64'(rlog[base].cyc), 64'(t + 2 + TIMEOUT));
    check("tie_resp_err",   64'(rlog[base].err), 64'd0);
    check("tie_resp_data",  rlog[base].data,     64'h0123_4567_89AB_CDEF);

    // Fill the FIFO while the controller stalls, then drain in order.
    rdy_delay = -1; dat_delay = 3; dat_value = 64'h1111_2222_3333_4444;
    base = rlog.size();
    for (int i = 0; i < 5; i++) push(PA'(19'h100 + i), (i % 2) == 0, 64'(i), t);
    req_valid_in = 1'b1; req_addr_in = 19'h105; req_we_in = 1'b0;
    check("fifo_full_ready", 64'(req_ready_out), 64'd0);
    repeat (3) tick();
    check("fifo_full_hold", 64'(req_ready_out), 64'd0);
    req_valid_in = 1'b0;
    rdy_delay = 0;
    push(19'h105, 1'b0, '0, t);
    wait_resp(base + 6);
    for (int i = 0; i < 6; i++) check("order_addr", 64'(rlog[base + i].addr), 64'(19'h100 + i));

    // Reset in the middle of a read with more requests queued.
    rdy_delay = 0; dat_delay = -1;
    base = rlog.size();
    push(19'h00321, 1'b0, '0, t);
    push(19'h00322, 1'b1, 64'hAA, t);
    push(19'h00323, 1'b1, 64'hBB, t);
    repeat (8) tick();
    rst_in = 1'b1;
    repeat (3) tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    check("ready_after_midreset", 64'(req_ready_out), 64'd1);
    check("resp_after_midreset",  64'(resp_valid_out), 64'd0);
    repeat (100) tick();
    check("reset_no_resp", 64'(rlog.size()), 64'(base));

    // Random traffic on both sides.
    base = rlog.size();
    ctl_random = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      req_valid_in = ($urandom_range(0, 1) == 1);
      req_addr_in  = PA'($urandom);
      req_we_in    = ($urandom_range(0, 1) == 1);
      req_wdata_in = {$urandom, $urandom};
      tick();
    end
    req_valid_in = 1'b0;
    ctl_random = 1'b0; rdy_delay = 0; dat_delay = 2;
    g = 0;
    while ((has_cur || mq.size() != 0) && g < 3000) begin tick(); g++; end
    check("random_drained", 64'(has_cur || mq.size() != 0), 64'd0);
    check("random_traffic", 64'(rlog.size() - base > 50), 64'd1);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
